// File: rtl/arb_tree_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_tree_pkg
// Brief    : Candidate layout helpers and the win rule for the max-arbitration tree.
// Revision : 1.0 - initial release
// ============================================================================
package arb_tree_pkg;

    // Candidates travel as packed vectors {found, index, value}.
    // Values wider than this are not supported by cmp_sel.
    localparam int CMP_MAX_W = 256;

    function automatic int cand_width(input int iw, input int w);
        return 1 + iw + w;
    endfunction

    // Returns 1 when b (higher index range) beats a; ties go to a.
    function automatic logic cmp_sel(
        input logic                 a_found,
        input logic [CMP_MAX_W-1:0] a_value,
        input logic                 b_found,
        input logic [CMP_MAX_W-1:0] b_value
    );
        return b_found && (!a_found || (b_value > a_value));
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_tree_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : arb_tree_pipe_if
// Brief    : Input vector / result handshake bundle of the arbitration tree.
// Revision : 1.0 - initial release
// ============================================================================
interface arb_tree_pipe_if #(
    parameter int N = 8,
    parameter int W = 32
);
    localparam int IW = $clog2(N);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  values [N];
    logic [N-1:0]  enable;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_index;
    logic [W-1:0]  out_value;
    logic          out_found;

    modport master (
        output in_valid, values, enable, out_ready,
        input  in_ready, out_valid, out_index, out_value, out_found
    );

    modport slave (
        input  in_valid, values, enable, out_ready,
        output in_ready, out_valid, out_index, out_value, out_found
    );
endinterface
`default_nettype wire

// File: rtl/arb_tree_level.sv
`default_nettype none
// ============================================================================
// Module   : arb_tree_level
// Brief    : One registered tree level: reduces NIN candidates to ceil(NIN/2).
// Revision : 1.0 - initial release
// ============================================================================
module arb_tree_level
    import arb_tree_pkg::*;
#(
    parameter int NIN = 2,
    parameter int IW  = 1,
    parameter int W   = 32,
    localparam int CW   = cand_width(IW, W),
    localparam int NOUT = (NIN + 1) / 2
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_advance,
    input  wire logic [NIN*CW-1:0]   i_cand,
    output logic      [NOUT*CW-1:0]  o_cand
);

    logic [2*NOUT*CW-1:0] w_pad;
    logic [NOUT*CW-1:0]   w_next;
    logic [NOUT*CW-1:0]   r_cand;

    // An odd trailing candidate is paired with an empty (never winning) one.
    assign w_pad = (2*NOUT*CW)'(i_cand);

    for (genvar j = 0; j < NOUT; j++) begin : g_pair
        logic [CW-1:0] w_a;
        logic [CW-1:0] w_b;
        logic [CW-1:0] w_win;
        logic          w_b_wins;

        assign w_a      = w_pad[2*j*CW +: CW];
        assign w_b      = w_pad[(2*j+1)*CW +: CW];
        assign w_b_wins = cmp_sel(w_a[CW-1], CMP_MAX_W'(w_a[W-1:0]),
                                  w_b[CW-1], CMP_MAX_W'(w_b[W-1:0]));
        assign w_win    = w_b_wins ? w_b : w_a;
        // A disabled leaf still carries its index; an empty result must be all zero.
        assign w_next[j*CW +: CW] = w_win[CW-1] ? w_win : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand <= '0;
        end else if (i_advance) begin
            r_cand <= w_next;
        end
    end

    assign o_cand = r_cand;

endmodule
`default_nettype wire

// File: rtl/arb_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : arb_tree_pipe
// Brief    : Pipelined max-arbitration tree, one register per level, global stall.
// Revision : 1.0 - initial release
// ============================================================================
module arb_tree_pipe
    import arb_tree_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 32
) (
    input  wire logic      clk,
    input  wire logic      reset,
    arb_tree_pipe_if.slave bus
);

    localparam int IW       = $clog2(N);
    localparam int LEVELS   = $clog2(N);
    localparam int NPAD     = 1 << LEVELS;
    localparam int CW       = cand_width(IW, W);
    localparam int OFF_LAST = (2*NPAD - 2) * CW;

    // All tree stages packed back to back: stage s holds NPAD>>s candidates.
    logic [(2*NPAD-1)*CW-1:0] w_tree;
    logic [LEVELS-1:0]        r_vld;
    logic                     w_advance;
    logic [CW-1:0]            w_last;

    assign w_advance   = !r_vld[LEVELS-1] || bus.out_ready;
    assign bus.in_ready = w_advance;

    for (genvar i = 0; i < NPAD; i++) begin : g_leaf
        if (i < N) begin : g_src
            assign w_tree[i*CW +: CW] = {bus.enable[i], IW'(i), bus.values[i]};
        end else begin : g_pad
            assign w_tree[i*CW +: CW] = '0;
        end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int NIN     = NPAD >> k;
        localparam int OFF_IN  = (2*NPAD - (2*NPAD >> k)) * CW;
        localparam int OFF_OUT = (2*NPAD - (NPAD >> k)) * CW;

        arb_tree_level #(
            .NIN (NIN),
            .IW  (IW),
            .W   (W)
        ) u_level (
            .clk       (clk),
            .rst       (reset),
            .i_advance (w_advance),
            .i_cand    (w_tree[OFF_IN +: NIN*CW]),
            .o_cand    (w_tree[OFF_OUT +: (NIN/2)*CW])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
        end else if (w_advance) begin
            r_vld <= (r_vld << 1) | LEVELS'(bus.in_valid);
        end
    end

    assign w_last        = w_tree[OFF_LAST +: CW];
    assign bus.out_valid = r_vld[LEVELS-1];
    assign bus.out_found = w_last[CW-1];
    assign bus.out_index = w_last[W +: IW];
    assign bus.out_value = w_last[W-1:0];

endmodule
`default_nettype wire

// File: doc/arb_tree_pipe.md
Name: arb_tree_pipe

Overview:
- Parametrised, pipelined max-arbitration tree for the interrupt priority path.
- Selects the highest-valued enabled entry among N inputs and returns its index, its value and a found flag.
- Generalises the combinational 8x32-bit max tree: any N ≥ 2, any value width, per-input enable mask, deterministic lowest-index tie-break, one register stage per tree level, valid/ready flow control.
- Sits between the per-source priority registers and the dispatch/preemption logic.

Parameters:
- N, 8, number of competing inputs (≥ 2; need not be a power of two).
- W, 32, width of each value.
- IW, $clog2(N), index width (derived; not overridden).
- LEVELS, $clog2(N), number of tree levels, equal to the pipeline depth (derived).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block accepts a vector this cycle
- values  in  N x W  unpacked array; element [i] is the value of source i
- enable  in  N  bit i=1 lets source i compete
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_index  out  IW  index of the winner
- out_value  out  W  value of the winner
- out_found  out  1  at least one input was enabled

Behaviour:
- Reset (async assert, sync deassert by the environment):
  - All stage valid bits clear; out_valid=0, out_index=0, out_value=0, out_found=0.
  - in_ready=1 as soon as reset is low.
- Node candidate = {found, index, value}. Leaf i = {enable[i], i, values[i]}.
- Padding: leaves i ≥ N are {0,0,0}.
- Compare node a (lower index range) vs b (higher):
  - b wins iff b.found && (!a.found || b.value > a.value), unsigned compare.
  - Otherwise a wins. Equal values therefore give the lower index.
  - When neither is found, the result is {0,0,0}.
- Pipeline:
  - Level k (1..LEVELS) combines the pairs from level k-1 and is registered, together with a stage valid bit.
  - The last level's register drives the outputs.
  - Latency is LEVELS cycles from an accepted input to out_valid (N=8 gives 3; N=5 gives 3; N=2 gives 1).
- Flow control, global stall:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - When advance=1, every stage loads from its predecessor and stage 1 valid loads in_valid && in_ready.
  - When advance=0, all stages hold, including data and valid bits. Outputs are stable while out_valid && !out_ready.
  - Bubbles are not compressed; throughput is 1 result/cycle with out_ready held high.
- Data registers of invalid stages may hold stale data. Outputs are only meaningful while out_valid=1, except that they are zeroed by reset.
- enable all zero → out_found=0, out_index=0, out_value=0, with out_valid asserted normally.
- Reset mid-operation: all in-flight results are discarded; none are emitted after reset.
- Inputs are sampled only on an accepted cycle. Changes to values/enable while in_ready=0 have no effect.

Decomposition:
- Package arb_tree_pkg holds:
  - a parameterised candidate struct type helper (found, index, value), or typedef macros when parameterised typedefs are impractical;
  - the function cmp_sel(a, b) implementing the win rule.
- Sub-module arb_tree_level: one registered level (parameters NIN, IW, W). It takes an array of candidates plus an advance strobe and produces ceil(NIN/2) registered candidates. It is generated LEVELS times.
- The top adds the valid chain, padding and the handshake.

Test Plan:
- N=8, W=32, values {8,9,6,1,5,5,7,6}, enable=8'hFF, out_ready=1 → after 3 cycles out_index=1, out_value=9, out_found=1.
- Same values, enable=8'hFD (source 1 masked) → out_index=0, out_value=8. Tie test values {1,1,5,5,2,0,0,0} → out_index=2, out_value=5.
- enable=0 with any values → out_valid=1 after 3 cycles, out_found=0, out_index=0, out_value=0.
- Streaming plus backpressure:
  - Feed 6 vectors back-to-back, winners at indices 0..5.
  - Drop out_ready for 4 cycles mid-stream.
  - Required: in_ready=0 during the stall, outputs held constant, all 6 results appear in order with no loss or duplication.
- N=5, W=4, values {3,15,15,2,9}, enable=5'h1F → latency 3, out_index=1, out_value=15. Padding never wins.
- Assert reset for 1 cycle with 2 vectors in flight → out_valid=0 immediately (asynchronous). No stale result is emitted afterwards; the next accepted vector produces a correct result at latency 3.
